car_alarm_driver: RTL and testbench

Converts the level-sensitive alarm condition from the car-warning logic into a timed buzzer pattern with a steady warning lamp. Sits downstream of the combinational warning decode: it takes that block's alarm level as its request and drives the buzzer and lamp. It supports driver muting, a bounded beep count and a status count for the dashboard.

---
 rtl/car_alarm_pkg.sv | 17 +
 rtl/tick_prescaler.sv | 36 +++
 rtl/car_alarm_driver.sv | 106 ++++++++++
 tb/tb_car_alarm_driver.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/car_alarm_pkg.sv
// car_alarm_pkg: shared FSM state type, beep counter width and counter-width helper
package car_alarm_pkg;

    typedef enum logic [2:0] {IDLE, ON, OFF, HOLD, MUTED} state_t;

    localparam int BEEP_CNT_W = 8;

    // Bits needed for a counter running 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk into a one-cycle tick every CLK_DIV cycles
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   clr   in  restarts the count at 0 so the next tick is CLK_DIV cycles away
//   tick  out high for the one cycle in which the count equals CLK_DIV-1
module tick_prescaler
    import car_alarm_pkg::*;
#(
    parameter int CLK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = cnt_w(CLK_DIV);

    if (CLK_DIV < 1) begin : g_bad_div
        $fatal(1, "tick_prescaler: CLK_DIV must be >= 1");
    end

    logic [W-1:0] r_cnt;

    assign tick = (r_cnt == W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (clr || tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/car_alarm_driver.sv
// car_alarm_driver: turns a level alarm request into a timed buzzer pattern plus steady lamp
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   alarm_req in  alarm level from the warning decode
//   mute      in  driver mute request
//   buzzer    out buzzer drive, high only while a beep is sounding
//   lamp      out warning lamp, high while an alarm is being served
//   busy      out high in any state other than IDLE
//   beep_cnt  out beeps started in the current alarm episode
module car_alarm_driver
    import car_alarm_pkg::*;
#(
    parameter int CLK_DIV        = 1000,
    parameter int BEEP_ON_TICKS  = 2,
    parameter int BEEP_OFF_TICKS = 3,
    parameter int MAX_BEEPS      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alarm_req,
    input  logic                  mute,
    output logic                  buzzer,
    output logic                  lamp,
    output logic                  busy,
    output logic [BEEP_CNT_W-1:0] beep_cnt
);

    localparam int TW = cnt_w(max2(BEEP_ON_TICKS, BEEP_OFF_TICKS));
    localparam logic [TW-1:0] ON_LIM  = TW'(BEEP_ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LIM = TW'(BEEP_OFF_TICKS - 1);
    localparam logic [BEEP_CNT_W-1:0] MAX_B = BEEP_CNT_W'(MAX_BEEPS);

    if (CLK_DIV < 1 || BEEP_ON_TICKS < 1 || BEEP_OFF_TICKS < 1 ||
        MAX_BEEPS < 0 || MAX_BEEPS > 255) begin : g_bad_param
        $fatal(1, "car_alarm_driver: illegal parameter value");
    end

    state_t                r_state;
    state_t                w_next;
    logic                  w_entry;
    logic                  w_tick;
    logic                  w_done;
    logic [TW-1:0]         r_tick_cnt;
    logic [BEEP_CNT_W-1:0] r_beep_cnt;

    // Any state change restarts the prescaler and tick counter so each phase is tick-aligned.
    assign w_entry = (w_next != r_state);

    tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_entry),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Priority: request drop, then mute, then phase expiry.
    always_comb begin
        w_next = r_state;
        w_done = w_tick && (r_tick_cnt == ((r_state == ON) ? ON_LIM : OFF_LIM));
        case (r_state)
            IDLE:    w_next = alarm_req ? ON : IDLE;
            ON:      w_next = !alarm_req ? IDLE :
                              mute       ? MUTED :
                              !w_done    ? ON :
                              (MAX_BEEPS != 0 && r_beep_cnt == MAX_B) ? HOLD : OFF;
            OFF:     w_next = !alarm_req ? IDLE :
                              mute       ? MUTED :
                              w_done     ? ON : OFF;
            default: w_next = alarm_req ? r_state : IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tick_cnt <= '0;
        else if (w_entry)
            r_tick_cnt <= '0;
        else if (w_tick)
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // Counts beeps as they start; saturates so unlimited mode never wraps to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_beep_cnt <= '0;
        else if (w_next == IDLE)
            r_beep_cnt <= '0;
        else if (w_next == ON && r_state == IDLE)
            r_beep_cnt <= BEEP_CNT_W'(1);
        else if (w_next == ON && r_state == OFF && r_beep_cnt != '1)
            r_beep_cnt <= r_beep_cnt + 1'b1;
    end

    assign buzzer   = (r_state == ON);
    assign lamp     = (r_state != IDLE);
    assign busy     = (r_state != IDLE);
    assign beep_cnt = r_beep_cnt;

endmodule

// File: tb/tb_car_alarm_driver.sv
// tb_car_alarm_driver: directed checks of the buzzer pattern, release, mute, priority, saturation and async reset
module tb_car_alarm_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alarm_req = 1'b0;
    logic       mute = 1'b0;
    logic       buzzer, lamp, busy;
    logic [7:0] beep_cnt;

    logic       rst_n2 = 1'b0;
    logic       req2 = 1'b0;
    logic       buz2, lamp2, busy2;
    logic [7:0] cnt2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    car_alarm_driver #(
        .CLK_DIV(4), .BEEP_ON_TICKS(2), .BEEP_OFF_TICKS(3), .MAX_BEEPS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .alarm_req(alarm_req), .mute(mute),
        .buzzer(buzzer), .lamp(lamp), .busy(busy), .beep_cnt(beep_cnt)
    );

    car_alarm_driver #(
        .CLK_DIV(1), .BEEP_ON_TICKS(1), .BEEP_OFF_TICKS(1), .MAX_BEEPS(0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n2), .alarm_req(req2), .mute(1'b0),
        .buzzer(buz2), .lamp(lamp2), .busy(busy2), .beep_cnt(cnt2)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic outs(input string tag, input int bz, input int lp, input int cnt);
        check({tag, ".buzzer"}, int'(buzzer), bz);
        check({tag, ".lamp"}, int'(lamp), lp);
        check({tag, ".busy"}, int'(busy), lp);
        check({tag, ".cnt"}, int'(beep_cnt), cnt);
    endtask

    initial begin
        #2;
        outs("reset", 0, 0, 0);
        check("reset2.busy", int'(busy2), 0);
        cyc(2);
        rst_n = 1'b1;
        rst_n2 = 1'b1;
        cyc(2);
        outs("post_reset", 0, 0, 0);

        // Basic: 8-cycle beeps, 12-cycle gaps, HOLD after the third beep
        alarm_req = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            cyc();
            outs($sformatf("basic%0d", k),
                 int'((k <= 8) || (k >= 21 && k <= 28) || (k >= 41 && k <= 48)), 1,
                 (k <= 20) ? 1 : (k <= 40) ? 2 : 3);
        end
        alarm_req = 1'b0;
        cyc();
        outs("hold_release", 0, 0, 0);

        // Release in the middle of beep 2, then restart
        alarm_req = 1'b1;
        cyc(24);
        outs("mid_beep2", 1, 1, 2);
        alarm_req = 1'b0;
        cyc();
        outs("release", 0, 0, 0);
        alarm_req = 1'b1;
        cyc();
        outs("restart", 1, 1, 1);

        // Mute during the OFF phase of beep 1: stays silent past where beep 2 would start
        cyc(9);
        outs("off1", 0, 1, 1);
        mute = 1'b1;
        cyc();
        mute = 1'b0;
        for (int k = 11; k <= 40; k++) begin
            cyc();
            outs($sformatf("muted%0d", k), 0, 1, 1);
        end
        alarm_req = 1'b0;
        cyc();
        outs("muted_release", 0, 0, 0);

        // Mute in IDLE does nothing and is not remembered
        mute = 1'b1;
        cyc(3);
        outs("idle_mute", 0, 0, 0);
        mute = 1'b0;
        alarm_req = 1'b1;
        cyc();
        outs("after_idle_mute", 1, 1, 1);

        // Mute on the ON-expiry edge wins over ON->OFF
        cyc(7);
        outs("on_last", 1, 1, 1);
        mute = 1'b1;
        cyc();
        mute = 1'b0;
        outs("mute_at_expiry", 0, 1, 1);
        for (int k = 10; k <= 25; k++) begin
            cyc();
            outs($sformatf("expiry_muted%0d", k), 0, 1, 1);
        end
        alarm_req = 1'b0;
        cyc();
        outs("expiry_release", 0, 0, 0);

        // Drop together with mute while ON goes to IDLE
        alarm_req = 1'b1;
        cyc(3);
        outs("pre_drop", 1, 1, 1);
        alarm_req = 1'b0;
        mute = 1'b1;
        cyc();
        outs("drop_and_mute", 0, 0, 0);
        mute = 1'b0;
        cyc();

        // Async reset between edges while the buzzer is on
        alarm_req = 1'b1;
        cyc(3);
        outs("pre_arst", 1, 1, 1);
        #2 rst_n = 1'b0;
        #1 outs("arst_now", 0, 0, 0);
        alarm_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc(3);
        outs("arst_idle", 0, 0, 0);
        alarm_req = 1'b1;
        cyc();
        outs("arst_rearm", 1, 1, 1);
        alarm_req = 1'b0;
        cyc();

        // Unlimited count: alternating ON/OFF every cycle, count saturating at 255
        req2 = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            cyc();
            check($sformatf("unl%0d.buzzer", k), int'(buz2), k % 2);
            check($sformatf("unl%0d.cnt", k), int'(cnt2), ((k + 1) / 2 > 255) ? 255 : (k + 1) / 2);
        end
        check("unl.lamp", int'(lamp2), 1);
        req2 = 1'b0;
        cyc();
        check("unl_release.cnt", int'(cnt2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
